seq_bit_serializer: RTL and testbench
=====================================

# seq_bit_serializer

Parallel-to-serial front end for the 1101 sequence detector. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `dout`, which drives the detector's `din` directly. When no word is in flight, `dout` holds a fixed idle level, so the detector always sees a defined bit every cycle.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 first.
- IDLE_BIT, 0, level driven on `dout` when no word is being shifted.

- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to serialize; sampled only on handshake.
- load  input  1  upstream valid; word transfers when `load && ready` at a rising edge.
- ready  output  1  block can accept a word this cycle.
- dout  output  1  registered serial bit; connects to the detector's `din`.
- bit_valid  output  1  registered; high while `dout` carries a payload bit.
- last_bit  output  1  registered; high during the final bit of a word.

## Operation
- States: IDLE, SHIFT. Encoded as a 1-bit enum.
- IDLE:
  - `dout` = IDLE_BIT, `bit_valid` = 0, `ready` = 1.
  - On `load`, capture `data_in` into the shift register, load the down-counter with WIDTH-1, and go to SHIFT.
- SHIFT:
  - Each cycle, present the current head bit on `dout` with `bit_valid` = 1, shift the register one position, and decrement the counter.
  - When the counter reaches 0, `last_bit` = 1 and `ready` = 1.
- Last-bit cycle with `load` high: accept the new word and stay in SHIFT. The first bit of the new word follows with no gap (back-to-back).
- Last-bit cycle with `load` low: return to IDLE.
- `ready` is combinational from registered state only: `(state==IDLE) || last_bit`, gated to 0 while `reset` is high. It never depends on `load`.
- `load` while `ready` = 0 is ignored and the word is not captured. Upstream must hold `data_in`/`load` until the handshake.
- Counter width is $clog2(WIDTH). It counts WIDTH-1 down to 0 with no wrap; reload only happens on handshake.
- Shift direction follows MSB_FIRST. Vacated bit positions fill with IDLE_BIT.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `dout` = IDLE_BIT, `bit_valid` = 0, `last_bit` = 0.
  - Shift register and counter = 0.
  - `ready` = 0 while reset is asserted and 1 in the first cycle after release.
- Latency: for a handshake at edge N, the first payload bit is on `dout` from edge N+1 and the last bit from edge N+WIDTH.
- Throughput: one word per WIDTH cycles with continuous `load`.
- Reset mid-word: the word is discarded and there is no partial output afterwards. `dout` returns to IDLE_BIT, so the detector sees idle bits.
- Simultaneous last bit and new `load`: `last_bit` of the old word and the first bit of the new word occupy consecutive cycles, with `bit_valid` continuously high.

## Structure
- Shared package `seq_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT};
  - default constants `SER_WIDTH_DEF` = 8 and `SER_IDLE_BIT` = 0.
  - The detector's state typedef also moves into this package.
- Single module with no sub-module. Shift register, counter and FSM fit in one always block plus the `ready` assign.

## Test plan
- Reset then idle 5 cycles -> `dout`=0, `bit_valid`=0, `ready`=1 after release.
- `data_in`=8'hDA (1101_1010), MSB_FIRST=1, one `load` -> `dout` 1,1,0,1,1,0,1,0 on 8 consecutive cycles; `last_bit` only on the 8th; then idle 0. Downstream detector pulses once.
- Same word with MSB_FIRST=0 -> `dout` 0,1,0,1,1,0,1,1.
- Back-to-back 8'hDA then 8'hB6 with `load` held -> 16 contiguous valid bits with no idle gap; `ready` high only on bit 8 and bit 16.
- `load` pulsed mid-word (bit 3 of 8'hDA) with `data_in`=8'hFF -> ignored; output still 8'hDA's bits, and 8'hFF never appears.
- Assert `reset` during bit 4 of 8'hDA -> `dout`=0 and `bit_valid`=0 immediately (asynchronously); after release, `ready`=1 and no remaining bits are emitted.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the 1101 sequence detector and its serializer front end.
package seq_pkg;

    localparam int   SER_WIDTH_DEF = 8;
    localparam logic SER_IDLE_BIT  = 1'b0;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    typedef enum logic [1:0] {
        DET_S0,
        DET_S1,
        DET_S11,
        DET_S110
    } det_state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end feeding the 1101 detector's din.
// One word per WIDTH cycles; a word accepted on its predecessor's last bit follows with no gap.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = SER_WIDTH_DEF,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             dout,
    output logic             bit_valid,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH);

    ser_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             hs;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST)
            return {w[WIDTH-2:0], IDLE_BIT};
        else
            return {IDLE_BIT, w[WIDTH-1:1]};
    endfunction

    assign ready = !reset && ((state == IDLE) || last_bit);
    assign hs    = load && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            dout      <= IDLE_BIT;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        sreg  <= data_in;
                        cnt   <= CW'(WIDTH - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        // Back-to-back: the new word's head goes straight to dout.
                        if (hs) begin
                            dout      <= head(data_in);
                            sreg      <= advance(data_in);
                            cnt       <= CW'(WIDTH - 2);
                            bit_valid <= 1'b1;
                            last_bit  <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            dout      <= IDLE_BIT;
                            bit_valid <= 1'b0;
                            last_bit  <= 1'b0;
                        end
                    end else begin
                        dout      <= head(sreg);
                        sreg      <= advance(sreg);
                        bit_valid <= 1'b1;
                        last_bit  <= (cnt == '0);
                        if (cnt != '0)
                            cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: MSB-first and LSB-first instances
// driven in parallel, each checked against a queue of expected serial bits.
module tb_seq_bit_serializer;
    import seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [1:0]   ready_w, dout_w, bv_w, lb_w;

    int n_assert = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int a0;

    bit exp_q [2][$];
    bit cur_bit   [2];
    bit cur_valid [2];
    bit cur_last  [2];

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready_w[0]), .dout(dout_w[0]),
        .bit_valid(bv_w[0]), .last_bit(lb_w[0])
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready_w[1]), .dout(dout_w[1]),
        .bit_valid(bv_w[1]), .last_bit(lb_w[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx,
                       input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0b expected=%0b", tag, idx, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        return !reset && (cur_last[i] || (!cur_valid[i] && exp_q[i].size() == 0));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            cur_bit[i]   = 1'b0;
            cur_valid[i] = 1'b0;
            cur_last[i]  = 1'b0;
        end
    endtask

    task automatic push_word(input int i, input logic [W-1:0] w);
        for (int k = 0; k < W; k++)
            exp_q[i].push_back(i == 0 ? w[W-1-k] : w[k]);
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk("dout", i, dout_w[i], cur_valid[i] ? cur_bit[i] : 1'b0);
            chk("bit_valid", i, bv_w[i], cur_valid[i]);
            chk("last_bit", i, lb_w[i], cur_last[i]);
            chk("ready", i, ready_w[i], m_ready(i));
        end
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic cycle();
        bit hs [2];
        for (int i = 0; i < 2; i++)
            hs[i] = load && m_ready(i);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                exp_q[i].delete();
                cur_valid[i] = 1'b0;
                cur_last[i]  = 1'b0;
            end else if (hs[i]) begin
                push_word(i, data_in);
                if (i == 0)
                    n_acc++;
                if (cur_last[i]) begin
                    cur_bit[i]   = exp_q[i].pop_front();
                    cur_valid[i] = 1'b1;
                    cur_last[i]  = 1'b0;
                end else begin
                    cur_valid[i] = 1'b0;
                    cur_last[i]  = 1'b0;
                end
            end else if (exp_q[i].size() != 0) begin
                cur_bit[i]   = exp_q[i].pop_front();
                cur_valid[i] = 1'b1;
                cur_last[i]  = (exp_q[i].size() == 0);
            end else begin
                cur_valid[i] = 1'b0;
                cur_last[i]  = 1'b0;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++)
            cycle();
    endtask

    task automatic send(input logic [W-1:0] w);
        data_in = w;
        load    = 1'b1;
        cycle();
        load    = 1'b0;
    endtask

    initial begin
        clear_model();

        // power-on reset, then idle
        idle(3);
        reset = 1'b0;
        idle(5);

        // single word 8'hDA
        send(8'hDA);
        idle(11);

        // back-to-back 8'hDA then 8'hB6 with load held
        a0      = n_acc;
        data_in = 8'hDA;
        load    = 1'b1;
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (n_acc == a0 + 1)
                data_in = 8'hB6;
            if (n_acc >= a0 + 2)
                load = 1'b0;
        end
        load = 1'b0;
        chk("b2b_accepts", 0, (n_acc == a0 + 2), 1'b1);

        // load pulsed on bit 3 with 8'hFF must be ignored
        send(8'hDA);
        idle(3);
        data_in = 8'hFF;
        load    = 1'b1;
        cycle();
        load    = 1'b0;
        data_in = '0;
        idle(10);

        // asynchronous reset during bit 4
        send(8'hDA);
        idle(4);
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_dout", i, dout_w[i], 1'b0);
            chk("async_bit_valid", i, bv_w[i], 1'b0);
            chk("async_ready", i, ready_w[i], 1'b0);
        end
        clear_model();
        @(negedge clk);
        cycle();
        reset = 1'b0;
        idle(10);

        for (int i = 0; i < 2; i++)
            chk("drained", i, (exp_q[i].size() == 0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
